mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles waited for bus_ack before abort (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 op_valid  input  1  MEM-stage access request; sampled only in IDLE.
REQ-005 MemRead  input  3  load code: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw.
REQ-006 MemWr  input  2  store code: 00 none, 01 sb, 10 sh, 11 sw.
REQ-007 addr  input  32  byte address (ALU result).
REQ-008 wdata  input  32  store data, rt value, right-justified.
REQ-009 busy  output  1  high whenever state != IDLE; pipeline stall.
REQ-010 done  output  1  one-cycle pulse ending each accepted access.
REQ-011 rdata  output  32  extended load result, valid from done, held until next done.
REQ-012 err  output  1  qualifies done: access failed.
REQ-013 err_code  output  2  01 misaligned, 10 bus timeout, 11 illegal op.
REQ-014 bus_req  output  1  bus request, held until ack or timeout.
REQ-015 bus_we  output  1  1 store, 0 load.
REQ-016 bus_addr  output  32  {addr[31:2],2'b00}.
REQ-017 bus_be  output  4  byte-lane enables, bit k = byte addr[1:0]==k.
REQ-018 bus_wdata  output  32  lane-replicated store data.
REQ-019 bus_rdata  input  32  read word, valid with bus_ack.
REQ-020 bus_ack  input  1  completion, one cycle, meaningful only while bus_req high.

Function
REQ-021 States IDLE, REQ, DONE; IDLE->REQ on accepted legal op; REQ->DONE on bus_ack or timeout; DONE->IDLE unconditionally.
REQ-022 Access accepted in IDLE when op_valid and (MemRead!=0 or MemWr!=0); addr, wdata, codes latched at that edge.
REQ-023 op_valid with both codes zero: no action, stays IDLE.
REQ-024 Both codes nonzero, or MemRead in 110/111: IDLE->DONE directly, err=1, err_code=11, no bus cycle.
REQ-025 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): IDLE->DONE, err=1, err_code=01, no bus cycle.
REQ-026 bus_req=1 exactly while in REQ; bus_addr/bus_we/bus_be/bus_wdata stable throughout REQ.
REQ-027 bus_be: byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111; same pattern for loads.
REQ-028 bus_wdata: sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}; sw wdata.
REQ-029 Load capture at edge bus_ack sampled high: selected lane; lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged.
REQ-030 Stores and error completions set rdata=0.
REQ-031 8-bit wait counter cleared on REQ entry, increments per REQ cycle without ack; reaching TIMEOUT drops bus_req, enters DONE with err_code=10.
REQ-032 bus_ack on the timeout cycle counts as success (ack wins).
REQ-033 Minimum latency: accept edge -> 1 REQ cycle (ack same cycle) -> done in the following cycle; busy never exceeds TIMEOUT+2 cycles.
REQ-034 op_valid and bus_ack outside their sampling states are ignored.
REQ-035 err and err_code are 0 whenever done is 0.

Reset
REQ-036 rst asserted: immediately state=IDLE, busy=0, done=0, err=0, err_code=00, rdata=0, bus_req=0, bus_we=0, bus_be=0000, bus_addr=0, bus_wdata=0, counter=0.
REQ-037 Reset mid-REQ aborts the access without done; no retry after release.

Structure
REQ-038 Shared package mem_pkg holds MemRead/MemWr codes (matching the decoder's), state encoding, err_code constants.
REQ-039 Combinational sub-module mem_lane_align computes bus_be, bus_wdata, misaligned flag and load extension; FSM and counter stay in top.

Verification
REQ-040 lb addr=0x1003, bus_rdata=0x80FF_1234, ack after 2 REQ cycles -> bus_addr=0x1000, be=1000, rdata=0xFFFF_FF80, done 1 cycle, err=0.
REQ-041 sh addr=0x2002, wdata=0x0000_ABCD -> bus_we=1, be=1100, bus_wdata=0xABCD_ABCD, rdata=0, done.
REQ-042 lw addr=0x3001 -> no bus_req, done with err=1, err_code=01 on next cycle.
REQ-043 TIMEOUT=4, lw addr=0x40 with no ack -> bus_req high 4 cycles, then done err_code=10; ack on 4th cycle instead -> success.
REQ-044 MemRead=101 and MemWr=11 together -> err_code=11, no bus cycle; lhu addr=0x2 data 0x8001_0000 -> rdata=0x0000_8001.
REQ-045 rst pulsed during REQ -> bus_req and busy fall asynchronously, no done, next lw completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared definitions for the MEM-stage access unit: load/store
//            codes (same encoding as the instruction decoder), FSM state
//            encoding, error codes, access-size encoding and decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Load codes (MemRead)
    localparam logic [2:0] c_mr_none = 3'b000;
    localparam logic [2:0] c_mr_lb   = 3'b001;
    localparam logic [2:0] c_mr_lbu  = 3'b010;
    localparam logic [2:0] c_mr_lh   = 3'b011;
    localparam logic [2:0] c_mr_lhu  = 3'b100;
    localparam logic [2:0] c_mr_lw   = 3'b101;

    // Store codes (MemWr)
    localparam logic [1:0] c_mw_none = 2'b00;
    localparam logic [1:0] c_mw_sb   = 2'b01;
    localparam logic [1:0] c_mw_sh   = 2'b10;
    localparam logic [1:0] c_mw_sw   = 2'b11;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Error codes reported with done
    localparam logic [1:0] c_err_none     = 2'b00;
    localparam logic [1:0] c_err_misalign = 2'b01;
    localparam logic [1:0] c_err_timeout  = 2'b10;
    localparam logic [1:0] c_err_illegal  = 2'b11;

    // Access size
    typedef logic [1:0] mem_size_t;
    localparam mem_size_t c_sz_none = 2'd0;
    localparam mem_size_t c_sz_byte = 2'd1;
    localparam mem_size_t c_sz_half = 2'd2;
    localparam mem_size_t c_sz_word = 2'd3;

    // Both directions at once, or an unassigned load code.
    function automatic logic mem_illegal(input logic [2:0] mr, input logic [1:0] mw);
        return ((mr != c_mr_none) && (mw != c_mw_none)) || (mr > c_mr_lw);
    endfunction

    // Size is only meaningful for legal codes; illegal combinations are
    // screened out by mem_illegal before size matters.
    function automatic mem_size_t mem_size(input logic [2:0] mr, input logic [1:0] mw);
        mem_size_t s;
        s = c_sz_none;
        case (mr)
            c_mr_lb, c_mr_lbu: s = c_sz_byte;
            c_mr_lh, c_mr_lhu: s = c_sz_half;
            c_mr_lw:           s = c_sz_word;
            default:           s = c_sz_none;
        endcase
        case (mw)
            c_mw_sb: s = c_sz_byte;
            c_mw_sh: s = c_sz_half;
            c_mw_sw: s = c_sz_word;
            default: ;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational byte-lane logic: lane enables, store-data lane
//            replication, alignment check and load-data extraction/extension.
// Ports    : i_mem_read/i_mem_wr - access codes
//            i_addr_lo           - byte offset within the word
//            i_wdata             - right-justified store data
//            i_rdata             - bus read word
//            o_be, o_wdata       - lane enables / replicated store data
//            o_misaligned        - access crosses its natural alignment
//            o_rdata_ext         - extended load result
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_mem_read,
    input  logic [1:0]  i_mem_wr,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    output logic [31:0] o_rdata_ext
);

    mem_size_t   w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_size       = mem_size(i_mem_read, i_mem_wr);
        o_be         = 4'b0000;
        o_wdata      = 32'd0;
        o_misaligned = 1'b0;
        case (w_size)
            c_sz_byte: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            c_sz_half: begin
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            c_sz_word: begin
                o_be         = 4'b1111;
                o_wdata      = i_wdata;
                o_misaligned = |i_addr_lo;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_mem_read)
            c_mr_lb:  o_rdata_ext = {{24{w_byte[7]}}, w_byte};
            c_mr_lbu: o_rdata_ext = {24'd0, w_byte};
            c_mr_lh:  o_rdata_ext = {{16{w_half[15]}}, w_half};
            c_mr_lhu: o_rdata_ext = {16'd0, w_half};
            c_mr_lw:  o_rdata_ext = i_rdata;
            default:  o_rdata_ext = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store sequencer. Accepts one access in IDLE,
//            runs a single bus cycle with timeout, and reports completion
//            with a one-cycle done pulse, error qualification and load data.
// Ports    : clk, rst (async, active-high)
//            op_valid, MemRead, MemWr, addr, wdata - pipeline request
//            busy, done, rdata, err, err_code      - pipeline response
//            bus_req/we/addr/be/wdata, bus_rdata, bus_ack - memory bus
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  MemRead,
    input  logic [1:0]  MemWr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_mr;
    logic [1:0]  r_mw;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [1:0]  r_err_code;

    logic        w_idle;
    logic        w_req;
    logic        w_store;
    logic [2:0]  w_sel_mr;
    logic [1:0]  w_sel_mw;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_wrep;
    logic        w_misaligned;
    logic [31:0] w_ext;
    logic        w_accept;
    logic        w_illegal;

    assign w_idle  = (r_state == c_st_idle);
    assign w_req   = (r_state == c_st_req);
    assign w_store = (r_mw != c_mw_none);

    // In IDLE the lane logic looks at the live request so alignment can be
    // judged at the accept edge; afterwards it works from the latched copy.
    assign w_sel_mr    = w_idle ? MemRead : r_mr;
    assign w_sel_mw    = w_idle ? MemWr   : r_mw;
    assign w_sel_addr  = w_idle ? addr    : r_addr;
    assign w_sel_wdata = w_idle ? wdata   : r_wdata;

    mem_lane_align u_align (
        .i_mem_read   (w_sel_mr),
        .i_mem_wr     (w_sel_mw),
        .i_addr_lo    (w_sel_addr[1:0]),
        .i_wdata      (w_sel_wdata),
        .i_rdata      (bus_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wrep),
        .o_misaligned (w_misaligned),
        .o_rdata_ext  (w_ext)
    );

    assign w_accept  = op_valid && ((MemRead != c_mr_none) || (MemWr != c_mw_none));
    assign w_illegal = mem_illegal(MemRead, MemWr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= 8'd0;
            r_mr       <= c_mr_none;
            r_mw       <= c_mw_none;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
            r_err_code <= c_err_none;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_mr    <= MemRead;
                        r_mw    <= MemWr;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_cnt   <= 8'd0;
                        if (w_illegal) begin
                            r_state    <= c_st_done;
                            r_err      <= 1'b1;
                            r_err_code <= c_err_illegal;
                            r_rdata    <= 32'd0;
                        end else if (w_misaligned) begin
                            r_state    <= c_st_done;
                            r_err      <= 1'b1;
                            r_err_code <= c_err_misalign;
                            r_rdata    <= 32'd0;
                        end else begin
                            r_state <= c_st_req;
                        end
                    end
                end
                c_st_req: begin
                    // Ack is tested first so an ack on the last allowed
                    // cycle completes the access successfully.
                    if (bus_ack) begin
                        r_state    <= c_st_done;
                        r_err      <= 1'b0;
                        r_err_code <= c_err_none;
                        r_rdata    <= w_store ? 32'd0 : w_ext;
                    end else if ((r_cnt + 8'd1) == c_timeout) begin
                        r_state    <= c_st_done;
                        r_err      <= 1'b1;
                        r_err_code <= c_err_timeout;
                        r_rdata    <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_st_done: begin
                    r_state    <= c_st_idle;
                    r_err      <= 1'b0;
                    r_err_code <= c_err_none;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Error flags are only ever set while in DONE, so they stay zero
    // outside the done pulse.
    assign busy     = !w_idle;
    assign done     = (r_state == c_st_done);
    assign err      = r_err;
    assign err_code = r_err_code;
    assign rdata    = r_rdata;

    // Bus outputs are driven only during REQ and rest at zero otherwise.
    assign bus_req   = w_req;
    assign bus_we    = w_req && w_store;
    assign bus_addr  = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign bus_be    = w_req ? w_be : 4'b0000;
    assign bus_wdata = (w_req && w_store) ? w_wrep : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. A driver issues
//            accesses and plays the bus side; expected completions are
//            queued and popped by a monitor whenever done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int C_TO = 4;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  MemRead;
    logic [1:0]  MemWr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  err_code;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    mem_access_unit #(.TIMEOUT(C_TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .MemRead   (MemRead),
        .MemWr     (MemWr),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .err_code  (err_code),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [1:0]  code;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_illegal(input logic [2:0] mr, input logic [1:0] mw);
        return (mr != 3'd0 && mw != 2'd0) || mr == 3'd6 || mr == 3'd7;
    endfunction

    function automatic int m_bytes(input logic [2:0] mr, input logic [1:0] mw);
        if (mw == 2'd1 || mr == 3'd1 || mr == 3'd2) return 1;
        if (mw == 2'd2 || mr == 3'd3 || mr == 3'd4) return 2;
        return 4;
    endfunction

    function automatic logic m_misal(input logic [2:0] mr, input logic [1:0] mw, input logic [31:0] a);
        int n;
        n = m_bytes(mr, mw);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] mr, input logic [1:0] mw, input logic [31:0] a);
        int n;
        n = m_bytes(mr, mw);
        if (n == 1) return 4'b0001 << a[1:0];
        if (n == 2) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] mw, input logic [31:0] wd);
        if (mw == 2'd1) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (mw == 2'd2) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] mr, input logic [31:0] a, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*a[1:0] +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (mr)
            3'd1:    return {{24{b[7]}}, b};
            3'd2:    return {24'd0, b};
            3'd3:    return {{16{h[15]}}, h};
            3'd4:    return {16'd0, h};
            default: return rd;
        endcase
    endfunction

    // ---------------- driver ----------------
    // ack_cyc: REQ cycle (1-based) on which bus_ack is returned; 0 = never.
    task automatic run_op(input logic [2:0] mr, input logic [1:0] mw, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_cyc, input logic [31:0] rd);
        exp_t e;
        logic bus_exp;
        bus_exp = 1'b0;
        e.err   = 1'b0;
        e.code  = 2'b00;
        e.rdata = 32'd0;
        if (m_illegal(mr, mw)) begin
            e.err = 1'b1; e.code = 2'b11;
        end else if (m_misal(mr, mw, a)) begin
            e.err = 1'b1; e.code = 2'b01;
        end else begin
            bus_exp = 1'b1;
            if (ack_cyc == 0 || ack_cyc > C_TO) begin
                e.err = 1'b1; e.code = 2'b10;
            end else if (mw == 2'd0) begin
                e.rdata = m_load(mr, a, rd);
            end
        end
        @(negedge clk);
        op_valid = 1'b1; MemRead = mr; MemWr = mw; addr = a; wdata = wd;
        q.push_back(e);
        @(posedge clk);
        #1;
        op_valid = 1'b0; MemRead = 3'd0; MemWr = 2'd0;
        addr = $urandom; wdata = $urandom;
        if (bus_exp) begin
            for (int c = 1; c <= C_TO; c++) begin
                @(negedge clk);
                chk("bus_req", {31'd0, bus_req}, 32'd1);
                chk("bus_addr", bus_addr, {a[31:2], 2'b00});
                chk("bus_be", {28'd0, bus_be}, {28'd0, m_be(mr, mw, a)});
                chk("bus_we", {31'd0, bus_we}, {31'd0, (mw != 2'd0)});
                if (mw != 2'd0) chk("bus_wdata", bus_wdata, m_wdata(mw, wd));
                if (c == ack_cyc) begin
                    bus_ack = 1'b1; bus_rdata = rd;
                end
                @(posedge clk);
                #1;
                bus_ack = 1'b0; bus_rdata = $urandom;
                if (c == ack_cyc) break;
            end
        end
        @(negedge clk);
        chk("done_lat", {31'd0, done}, 32'd1);
        chk("bus_req_off", {31'd0, bus_req}, 32'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexp_done", {31'd0, done}, 32'd0);
                end else begin
                    m_e = q.pop_front();
                    chk("err", {31'd0, err}, {31'd0, m_e.err});
                    chk("err_code", {30'd0, err_code}, {30'd0, m_e.code});
                    chk("rdata", rdata, m_e.rdata);
                end
            end else begin
                chk("err_quiet", {29'd0, err, err_code}, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; op_valid = 1'b0; MemRead = 3'd0; MemWr = 2'd0;
        addr = 32'd0; wdata = 32'd0; bus_rdata = 32'd0; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {29'd0, err, err_code}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus_ctl", {29'd0, bus_req, bus_we}, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_op(3'd1, 2'd0, 32'h0000_1003, 32'd0, 2, 32'h80FF_1234);      // lb
        run_op(3'd0, 2'd2, 32'h0000_2002, 32'h0000_ABCD, 1, 32'd0);      // sh
        run_op(3'd5, 2'd0, 32'h0000_3001, 32'd0, 1, 32'd0);              // lw misaligned
        run_op(3'd5, 2'd0, 32'h0000_0040, 32'd0, 0, 32'd0);              // lw timeout
        run_op(3'd5, 2'd0, 32'h0000_0040, 32'd0, 4, 32'hDEAD_BEEF);      // ack on last cycle
        run_op(3'd5, 2'd3, 32'h0000_0000, 32'd0, 1, 32'd0);              // both codes
        run_op(3'd4, 2'd0, 32'h0000_0002, 32'd0, 1, 32'h8001_0000);      // lhu
        run_op(3'd6, 2'd0, 32'h0000_0000, 32'd0, 1, 32'd0);              // bad load code
        run_op(3'd0, 2'd1, 32'h0000_0005, 32'h1234_5678, 3, 32'd0);      // sb
        run_op(3'd0, 2'd3, 32'h0000_0008, 32'hCAFE_F00D, 1, 32'd0);      // sw
        run_op(3'd3, 2'd0, 32'h0000_0006, 32'd0, 2, 32'h8001_0000);      // lh
        run_op(3'd2, 2'd0, 32'h0000_0001, 32'd0, 1, 32'h0000_F000);      // lbu
        run_op(3'd0, 2'd2, 32'h0000_0001, 32'h1, 1, 32'd0);              // sh misaligned

        // Request with no codes, and a stray ack while idle: both ignored.
        @(negedge clk);
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        chk("noop_busy", {31'd0, busy}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("idle_ack_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of REQ.
        @(negedge clk);
        op_valid = 1'b1; MemRead = 3'd5; addr = 32'h0000_0100;
        @(posedge clk);
        #1 op_valid = 1'b0; MemRead = 3'd0;
        @(negedge clk);
        chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_req_async", {31'd0, bus_req}, 32'd0);
        chk("rst_busy_async", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        run_op(3'd5, 2'd0, 32'h0000_0200, 32'd0, 1, 32'h0BAD_F00D);

        // Mixed random traffic.
        for (int i = 0; i < 24; i++) begin
            logic [2:0] mr;
            logic [1:0] mw;
            mr = 3'($urandom_range(0, 7));
            mw = 2'($urandom_range(0, 3));
            if (mr == 3'd0 && mw == 2'd0) mr = 3'd5;
            run_op(mr, mw, $urandom, $urandom, $urandom_range(0, C_TO), $urandom);
        end

        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
